hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 153 +++++++++++++++
 tb/tb_hazard_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard detection for a 5-stage core with multi-cycle
// EX operations (mult / matr). Detects load-use and taken-branch hazards and
// holds the front end while a multi-cycle op occupies EX.
// Optional build macro HAZARD_UNIT_STATS_EN adds saturating stall/flush counters.
module hazard_unit #(
   parameter int MUL_LAT  = 3,
   parameter int MATR_LAT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] id_opcode,
   input  logic [6:0] id_funct7,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       ex_memread,
   input  logic [4:0] ex_rd,
   input  logic       ex_branch_taken,
   output logic       ctrl_src,
   output logic       pc_write,
   output logic       ifid_write,
   output logic       ifid_flush,
   output logic       busy
`ifdef HAZARD_UNIT_STATS_EN
   ,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
`endif
);

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] F7_MUL    = 7'b0000001;
   localparam logic [6:0] F7_MATR   = 7'b0000010;

   // The issue cycle itself counts as the first EX cycle, and the last MULTI
   // cycle is cnt==0, so LAT-1 stall cycles need a start value of LAT-2.
   localparam logic [3:0] MUL_CNT  = 4'(MUL_LAT - 2);
   localparam logic [3:0] MATR_CNT = 4'(MATR_LAT - 2);

   typedef enum logic [0:0] {IDLE, MULTI} state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   logic       rs2_used;
   logic       load_use;
   logic       multi_id;
   logic [3:0] multi_cnt;

   // Hazard decode of the instruction in ID against the one in EX
   always_comb begin
      rs2_used  = (id_opcode == OP_RTYPE) || (id_opcode == OP_STORE) ||
                  (id_opcode == OP_BRANCH);
      load_use  = ex_memread && (ex_rd != 5'd0) &&
                  ((ex_rd == id_rs1) || (rs2_used && (ex_rd == id_rs2)));
      multi_id  = (id_opcode == OP_RTYPE) &&
                  ((id_funct7 == F7_MUL) || (id_funct7 == F7_MATR));
      multi_cnt = (id_funct7 == F7_MATR) ? MATR_CNT : MUL_CNT;
   end

   // Next state and combinational pipeline control outputs
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ctrl_src   = 1'b0;
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      busy       = 1'b0;
      if (rst) begin
         // Hold the front end and flush IF/ID while reset is asserted
         state_d    = IDLE;
         cnt_d      = 4'd0;
         ctrl_src   = 1'b1;
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (ex_branch_taken) begin
                  // Wrong-path instruction in ID is squashed; fetch redirects
                  ctrl_src   = 1'b1;
                  ifid_flush = 1'b1;
               end else if (load_use) begin
                  ctrl_src   = 1'b1;
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
               end else if (multi_id) begin
                  // Op issues normally this cycle; stall starts next cycle
                  state_d = MULTI;
                  cnt_d   = multi_cnt;
               end
            end
            MULTI: begin
               // EX is occupied by the multi op: all other hazards are moot
               ctrl_src   = 1'b1;
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               busy       = 1'b1;
               if (cnt_q == 4'd0) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end
         endcase
      end
   end

   // State and multi-cycle counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_UNIT_STATS_EN
   logic [15:0] stall_cnt_q, flush_cnt_q;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Saturating event counters; reset cycles are never counted
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= 16'd0;
         flush_cnt_q <= 16'd0;
      end else begin
         if (!pc_write) begin
            stall_cnt_q <= sat_inc16(stall_cnt_q);
         end
         if (ifid_flush) begin
            flush_cnt_q <= sat_inc16(flush_cnt_q);
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and randomized checks of hazard_unit against a
// cycle-level model built from a "stall cycles remaining" count.
module tb_hazard_unit;

   localparam int MUL_LAT  = 3;
   localparam int MATR_LAT = 8;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_S    = 7'b0100011;
   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] F7_MUL  = 7'b0000001;
   localparam logic [6:0] F7_MATR = 7'b0000010;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] id_opcode;
   logic [6:0] id_funct7;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       ex_memread;
   logic [4:0] ex_rd;
   logic       ex_branch_taken;
   logic       ctrl_src;
   logic       pc_write;
   logic       ifid_write;
   logic       ifid_flush;
   logic       busy;
`ifdef HAZARD_UNIT_STATS_EN
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;
   int          m_stall = 0;
   int          m_flush = 0;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int left    = 0;   // model: front-end stall cycles still owed to a multi op

   always #5 clk = ~clk;

   hazard_unit #(.MUL_LAT(MUL_LAT), .MATR_LAT(MATR_LAT)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_opcode       (id_opcode),
      .id_funct7       (id_funct7),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .ex_memread      (ex_memread),
      .ex_rd           (ex_rd),
      .ex_branch_taken (ex_branch_taken),
      .ctrl_src        (ctrl_src),
      .pc_write        (pc_write),
      .ifid_write      (ifid_write),
      .ifid_flush      (ifid_flush),
      .busy            (busy)
`ifdef HAZARD_UNIT_STATS_EN
      ,
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
`endif
   );

   task automatic chk(input string tag, input logic obs, input logic expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic set_nop();
      id_opcode       = OP_I;
      id_funct7       = 7'd0;
      id_rs1          = 5'd1;
      id_rs2          = 5'd2;
      ex_memread      = 1'b0;
      ex_rd           = 5'd0;
      ex_branch_taken = 1'b0;
   endtask

   // One clock: predict outputs from current inputs, check mid-cycle, advance model
   task automatic step(input string tag);
      logic rs2u, lu, mu;
      logic e_cs, e_pw, e_iw, e_fl, e_bz;
      int   lat;
      rs2u = (id_opcode == OP_R) || (id_opcode == OP_S) || (id_opcode == OP_B);
      lu   = ex_memread && (ex_rd != 5'd0) &&
             ((ex_rd == id_rs1) || (rs2u && (ex_rd == id_rs2)));
      mu   = (id_opcode == OP_R) && ((id_funct7 == F7_MUL) || (id_funct7 == F7_MATR));
      lat  = (id_funct7 == F7_MATR) ? MATR_LAT : MUL_LAT;
      if (rst)                  {e_cs, e_pw, e_iw, e_fl, e_bz} = 5'b10010;
      else if (left > 0)        {e_cs, e_pw, e_iw, e_fl, e_bz} = 5'b10001;
      else if (ex_branch_taken) {e_cs, e_pw, e_iw, e_fl, e_bz} = 5'b11110;
      else if (lu)              {e_cs, e_pw, e_iw, e_fl, e_bz} = 5'b10000;
      else                      {e_cs, e_pw, e_iw, e_fl, e_bz} = 5'b01100;
      @(negedge clk);
      chk({tag, ".ctrl_src"},   ctrl_src,   e_cs);
      chk({tag, ".pc_write"},   pc_write,   e_pw);
      chk({tag, ".ifid_write"}, ifid_write, e_iw);
      chk({tag, ".ifid_flush"}, ifid_flush, e_fl);
      chk({tag, ".busy"},       busy,       e_bz);
`ifdef HAZARD_UNIT_STATS_EN
      chk16({tag, ".stall_cnt"}, stall_cnt, 16'(m_stall));
      chk16({tag, ".flush_cnt"}, flush_cnt, 16'(m_flush));
`endif
      @(posedge clk);
      if (rst) begin
         left = 0;
      end else if (left > 0) begin
         left--;
      end else if (!ex_branch_taken && !lu && mu) begin
         left = lat - 1;
      end
`ifdef HAZARD_UNIT_STATS_EN
      if (rst) begin
         m_stall = 0;
         m_flush = 0;
      end else begin
         if (!e_pw && m_stall < 65535) m_stall++;
         if (e_fl && m_flush < 65535) m_flush++;
      end
`endif
      #1;
   endtask

   initial begin
      logic [6:0] ops [5];
      logic [6:0] f7s [4];
      ops[0] = OP_R; ops[1] = OP_S; ops[2] = OP_B; ops[3] = OP_I; ops[4] = OP_LW;
      f7s[0] = 7'd0; f7s[1] = F7_MUL; f7s[2] = F7_MATR; f7s[3] = 7'b0100000;

      // Reset state
      set_nop();
      rst = 1'b1;
      step("reset0");
      step("reset1");
      n_tests++;
      assert (dut.cnt_q === 4'd0) else begin
         n_fail++;
         $error("FAIL reset_cnt observed=%0d expected=0", dut.cnt_q);
      end
      rst = 1'b0;
      step("idle");

      // Load-use on rs2 of an R-type: exactly one bubble
      id_opcode = OP_R; id_rs1 = 5'd1; id_rs2 = 5'd5; ex_memread = 1'b1; ex_rd = 5'd5;
      step("lu_rs2");
      ex_memread = 1'b0;
      step("lu_after");

      // mult: two busy cycles after issue
      set_nop(); id_opcode = OP_R; id_funct7 = F7_MUL;
      step("mul_issue");
      set_nop();
      step("mul_busy1");
      step("mul_busy2");
      step("mul_done");

      // matr aborted by reset on its third MULTI cycle
      id_opcode = OP_R; id_funct7 = F7_MATR;
      step("matr_issue");
      set_nop();
      step("matr_busy1");
      step("matr_busy2");
      rst = 1'b1;
      step("matr_rst");
      rst = 1'b0;
      step("matr_abort_idle");
      n_tests++;
      assert (dut.cnt_q === 4'd0) else begin
         n_fail++;
         $error("FAIL abort_cnt observed=%0d expected=0", dut.cnt_q);
      end

      // Branch beats load-use and multi issue
      id_opcode = OP_R; id_funct7 = F7_MUL; id_rs1 = 5'd5; id_rs2 = 5'd5;
      ex_memread = 1'b1; ex_rd = 5'd5; ex_branch_taken = 1'b1;
      step("br_prio");
      set_nop();
      step("br_no_multi");

      // x0 never stalls; rs2 ignored for I-type
      id_opcode = OP_R; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_memread = 1'b1; ex_rd = 5'd0;
      step("x0_no_stall");
      id_opcode = OP_I; id_rs1 = 5'd1; id_rs2 = 5'd3; ex_memread = 1'b1; ex_rd = 5'd3;
      step("itype_rs2");

      // Counter scenario: matr then two load-use events
      set_nop(); rst = 1'b1;
      step("stats_rst");
      rst = 1'b0;
      id_opcode = OP_R; id_funct7 = F7_MATR;
      step("stats_matr");
      set_nop();
      for (int i = 0; i < MATR_LAT - 1; i++) step("stats_busy");
      id_opcode = OP_R; id_rs1 = 5'd7; ex_memread = 1'b1; ex_rd = 5'd7;
      step("stats_lu1");
      set_nop();
      step("stats_gap");
      id_opcode = OP_S; id_rs2 = 5'd9; ex_memread = 1'b1; ex_rd = 5'd9;
      step("stats_lu2");
      set_nop();
      step("stats_end");
`ifdef HAZARD_UNIT_STATS_EN
      chk16("stats_stall_total", stall_cnt, 16'd9);
      chk16("stats_flush_total", flush_cnt, 16'd0);
`endif

      // Randomized traffic with a small register pool so hazards collide often
      for (int i = 0; i < 400; i++) begin
         rst             = ($urandom_range(0, 49) == 0);
         id_opcode       = ops[$urandom_range(0, 4)];
         id_funct7       = f7s[$urandom_range(0, 3)];
         id_rs1          = 5'($urandom_range(0, 3));
         id_rs2          = 5'($urandom_range(0, 3));
         ex_memread      = 1'($urandom_range(0, 1));
         ex_rd           = 5'($urandom_range(0, 3));
         ex_branch_taken = ($urandom_range(0, 7) == 0);
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
